// File: rtl/rca128_mc_ctrl_pkg.sv
// Shared types and constants for the 128-bit ripple-carry adder multicycle controller.
package rca_pkg;

  localparam int RCA_WORD_W = 32;
  localparam int RCA_OP_W   = 128;

  typedef enum logic [1:0] {
    ST_LOAD_A,
    ST_LOAD_B,
    ST_SETTLE,
    ST_DRAIN
  } rca_state_e;

  function automatic int beats(input int op_w, input int word_w);
    return op_w / word_w;
  endfunction

endpackage

// File: rtl/rca128_mc_ctrl_if.sv
// Word-stream, adder-side and result-stream signals of rca128_mc_ctrl.
// out_OVF exists only when RCA128_OVF_EN is defined.
interface rca128_mc_ctrl_if #(
  parameter int WORD_W = rca_pkg::RCA_WORD_W,
  parameter int OP_W   = rca_pkg::RCA_OP_W
) ();

  logic [WORD_W-1:0] in_WDATA;
  logic              in_WVALID;
  logic              in_CIN;
  logic              out_WREADY;
  logic [OP_W-1:0]   out_OP_A;
  logic [OP_W-1:0]   out_OP_B;
  logic              out_CI;
  logic [OP_W-1:0]   in_SUM;
  logic              in_CO;
  logic [WORD_W-1:0] out_RDATA;
  logic              out_RVALID;
  logic              in_RREADY;
  logic              out_RLAST;
  logic              out_CO_FLAG;
`ifdef RCA128_OVF_EN
  logic              out_OVF;
`endif

  // The controller is the slave of the operand stream and the adder environment.
  modport slave (
    input  in_WDATA, in_WVALID, in_CIN, in_SUM, in_CO, in_RREADY,
    output out_WREADY, out_OP_A, out_OP_B, out_CI, out_RDATA, out_RVALID,
           out_RLAST, out_CO_FLAG
`ifdef RCA128_OVF_EN
    , output out_OVF
`endif
  );

  modport master (
    output in_WDATA, in_WVALID, in_CIN, in_SUM, in_CO, in_RREADY,
    input  out_WREADY, out_OP_A, out_OP_B, out_CI, out_RDATA, out_RVALID,
           out_RLAST, out_CO_FLAG
`ifdef RCA128_OVF_EN
    , input out_OVF
`endif
  );

endinterface

// File: rtl/rca128_mc_ctrl_word_pack.sv
// OP_W-bit operand register written one WORD_W slot at a time.
module rca_word_pack #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 128,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [OP_W-1:0]   data
);

  localparam int BEATS = OP_W / WORD_W;

  // NOTE: state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (we) begin
      for (int i = 0; i < BEATS; i++) begin
        if (idx == IDX_W'(i)) data[i*WORD_W +: WORD_W] <= wdata;
      end
    end
  end

endmodule

// File: rtl/rca128_mc_ctrl.sv
// Multicycle front/back-end for an external combinational ripple-carry adder.
// Optional macro RCA128_OVF_EN adds a signed-overflow flag (out_OVF).
module rca128_mc_ctrl
  import rca_pkg::*;
#(
  parameter int WORD_W     = RCA_WORD_W,
  parameter int OP_W       = RCA_OP_W,
  parameter int SETTLE_CYC = 4
) (
  input logic             in_CLK,
  input logic             in_RST,
  rca128_mc_ctrl_if.slave bus
);

  localparam int BEATS = beats(OP_W, WORD_W);
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_BEAT   = IDX_W'(BEATS - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);

  rca_state_e        state, state_nxt;
  logic [IDX_W-1:0]  beat_cnt;
  logic [3:0]        settle_cnt;
  logic [OP_W-1:0]   op_a, op_b, result;
  logic              ci, co_flag;
  logic              wready, rvalid, w_xfer, r_xfer, we_a, we_b;
  logic              beat_last, settle_done;
  logic [WORD_W-1:0] rdata;
`ifdef RCA128_OVF_EN
  logic              ovf;
`endif

  assign beat_last   = (beat_cnt == LAST_BEAT);
  assign settle_done = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);

  always_ff @(posedge in_CLK) begin
    if (in_RST) state <= ST_LOAD_A;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LOAD_A: if (w_xfer && beat_last) state_nxt = ST_LOAD_B;
      ST_LOAD_B: if (w_xfer && beat_last) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_done)         state_nxt = ST_DRAIN;
      ST_DRAIN:  if (r_xfer && beat_last) state_nxt = ST_LOAD_A;
      default:                            state_nxt = ST_LOAD_A;
    endcase
  end

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    wready = 1'b0;
    rvalid = 1'b0;
    rdata  = '0;
    unique case (state)
      ST_LOAD_A, ST_LOAD_B: wready = !in_RST;
      ST_DRAIN:             rvalid = !in_RST;
      default: ;
    endcase
    for (int i = 0; i < BEATS; i++) begin
      if (beat_cnt == IDX_W'(i)) rdata = result[i*WORD_W +: WORD_W];
    end
  end

  assign w_xfer = bus.in_WVALID && wready;
  assign r_xfer = rvalid && bus.in_RREADY;
  assign we_a   = w_xfer && (state == ST_LOAD_A);
  assign we_b   = w_xfer && (state == ST_LOAD_B);

  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      beat_cnt   <= '0;
      settle_cnt <= '0;
      ci         <= 1'b0;
      result     <= '0;
      co_flag    <= 1'b0;
`ifdef RCA128_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      if (w_xfer || r_xfer) beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
      settle_cnt <= (state == ST_SETTLE && !settle_done) ? settle_cnt + 4'd1 : 4'd0;
      if (we_a && beat_cnt == '0) ci <= bus.in_CIN;
      // The adder has had SETTLE_CYC full cycles of stable inputs by this edge.
      if (settle_done) begin
        result  <= bus.in_SUM;
        co_flag <= bus.in_CO;
`ifdef RCA128_OVF_EN
        ovf     <= (op_a[OP_W-1] == op_b[OP_W-1]) && (bus.in_SUM[OP_W-1] != op_a[OP_W-1]);
`endif
      end
    end
  end

  rca_word_pack #(.WORD_W(WORD_W), .OP_W(OP_W), .IDX_W(IDX_W)) u_pack_a (
    .clk(in_CLK), .rst(in_RST), .we(we_a), .idx(beat_cnt), .wdata(bus.in_WDATA), .data(op_a)
  );

  rca_word_pack #(.WORD_W(WORD_W), .OP_W(OP_W), .IDX_W(IDX_W)) u_pack_b (
    .clk(in_CLK), .rst(in_RST), .we(we_b), .idx(beat_cnt), .wdata(bus.in_WDATA), .data(op_b)
  );

  assign bus.out_WREADY  = wready;
  assign bus.out_OP_A    = op_a;
  assign bus.out_OP_B    = op_b;
  assign bus.out_CI      = ci;
  assign bus.out_RDATA   = rdata;
  assign bus.out_RVALID  = rvalid;
  assign bus.out_RLAST   = rvalid && beat_last;
  assign bus.out_CO_FLAG = co_flag;
`ifdef RCA128_OVF_EN
  assign bus.out_OVF     = ovf;
`endif

endmodule

// File: tb/tb_rca128_mc_ctrl.sv
// Directed bench for rca128_mc_ctrl with a behavioural 128-bit adder beside it.
// Define RCA128_OVF_EN to also exercise the overflow flag.
module tb_rca128_mc_ctrl;
  import rca_pkg::*;

  localparam int SETTLE_CYC = 4;
  localparam int BEATS      = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rca128_mc_ctrl_if #(.WORD_W(32), .OP_W(128)) bus ();

  rca128_mc_ctrl #(.WORD_W(32), .OP_W(128), .SETTLE_CYC(SETTLE_CYC)) dut (
    .in_CLK(clk),
    .in_RST(rst),
    .bus   (bus)
  );

  // Environment adder: the real VRCA_128 sits beside the controller.
  logic [128:0] add_res;
  assign add_res    = {1'b0, bus.out_OP_A} + {1'b0, bus.out_OP_B} + 129'(bus.out_CI);
  assign bus.in_SUM = add_res[127:0];
  assign bus.in_CO  = add_res[128];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input string tag, input logic [31:0] w, input logic cin);
    int n = 0;
    bus.in_WDATA  = w;
    bus.in_CIN    = cin;
    bus.in_WVALID = 1'b1;
    while (!bus.out_WREADY && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_wready_timeout"}, 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic send_ops(input string tag, input logic [127:0] a, input logic [127:0] b,
                          input logic cin, input bit gap);
    for (int i = 0; i < 2*BEATS; i++) begin
      if (i < BEATS) send_word(tag, a[i*32 +: 32], (i == 0) ? cin : 1'b0);
      else           send_word(tag, b[(i-BEATS)*32 +: 32], 1'b0);
      if (gap && i != 2*BEATS-1) begin
        bus.in_WVALID = 1'b0;
        @(negedge clk);
      end
    end
    bus.in_WVALID = 1'b0;
    bus.in_CIN    = 1'b0;
  endtask

  task automatic wait_rvalid(input string tag);
    int n = 0;
    while (!bus.out_RVALID && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_rvalid_timeout"}, 1'b0, 1'b1);
  endtask

  // Full operation: load, measure settle latency, drain and check every word.
  task automatic run_op(input string tag, input logic [127:0] a, input logic [127:0] b,
                        input logic cin, input logic [127:0] exp_sum, input logic exp_co,
                        input logic exp_ovf, input bit gap, input bit bp);
    int n = 0;
    logic [127:0] sum_v;
    sum_v = exp_sum;
    send_ops(tag, a, b, cin, gap);
    while (!bus.out_RVALID && n < 50) begin
      if (gap) begin
        bus.in_WVALID = 1'b1;
        bus.in_WDATA  = 32'hDEAD_BEEF;
        check($sformatf("%s_settle_wready%0d", tag, n), bus.out_WREADY, 1'b0);
      end
      @(negedge clk);
      n++;
    end
    bus.in_WVALID = 1'b0;
    check({tag, "_latency"}, n, SETTLE_CYC);
    check({tag, "_op_a"}, bus.out_OP_A, a);
    for (int i = 0; i < BEATS; i++) begin
      bus.in_RREADY = 1'b1;
      wait_rvalid(tag);
      check($sformatf("%s_rdata%0d", tag, i), bus.out_RDATA, sum_v[i*32 +: 32]);
      check($sformatf("%s_rlast%0d", tag, i), bus.out_RLAST, (i == BEATS-1));
      check($sformatf("%s_co%0d", tag, i), bus.out_CO_FLAG, exp_co);
`ifdef RCA128_OVF_EN
      check($sformatf("%s_ovf%0d", tag, i), bus.out_OVF, exp_ovf);
`endif
      @(negedge clk);
      if (bp && i == 1) begin
        bus.in_RREADY = 1'b0;
        bus.in_WVALID = 1'b1;
        bus.in_WDATA  = 32'hBAD0_0000;
        for (int k = 0; k < 7; k++) begin
          check($sformatf("%s_bp_rvalid%0d", tag, k), bus.out_RVALID, 1'b1);
          check($sformatf("%s_bp_rdata%0d", tag, k), bus.out_RDATA, sum_v[64 +: 32]);
          check($sformatf("%s_bp_rlast%0d", tag, k), bus.out_RLAST, 1'b0);
          check($sformatf("%s_bp_wready%0d", tag, k), bus.out_WREADY, 1'b0);
          @(negedge clk);
        end
        bus.in_WVALID = 1'b0;
      end
    end
    bus.in_RREADY = 1'b0;
    check({tag, "_end_rvalid"}, bus.out_RVALID, 1'b0);
    check({tag, "_end_wready"}, bus.out_WREADY, 1'b1);
  endtask

  task automatic apply_reset(input string tag);
    rst           = 1'b1;
    bus.in_WVALID = 1'b0;
    bus.in_RREADY = 1'b0;
    #1;
    check({tag, "_wready_in_rst"}, bus.out_WREADY, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({tag, "_wready"}, bus.out_WREADY, 1'b1);
    check({tag, "_rvalid"}, bus.out_RVALID, 1'b0);
    check({tag, "_rlast"},  bus.out_RLAST,  1'b0);
    check({tag, "_op_a"},   bus.out_OP_A,   128'h0);
    check({tag, "_op_b"},   bus.out_OP_B,   128'h0);
    check({tag, "_ci"},     bus.out_CI,     1'b0);
    check({tag, "_co"},     bus.out_CO_FLAG, 1'b0);
`ifdef RCA128_OVF_EN
    check({tag, "_ovf"},    bus.out_OVF,    1'b0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_WDATA  = '0;
    bus.in_WVALID = 1'b0;
    bus.in_CIN    = 1'b0;
    bus.in_RREADY = 1'b0;
    @(negedge clk);
    @(negedge clk);
    apply_reset("rst0");

    // Carry ripples through all 128 bits.
    run_op("maxcarry", {128{1'b1}}, 128'h1, 1'b0, 128'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    run_op("order", 128'h00000004_00000003_00000002_00000001,
           128'h00000040_00000030_00000020_00000010, 1'b1,
           128'h00000044_00000033_00000022_00000012, 1'b0, 1'b0, 1'b0, 1'b0);

    run_op("bp", 128'h00000004_00000003_00000002_00000001,
           128'h00000040_00000030_00000020_00000010, 1'b0,
           128'h00000044_00000033_00000022_00000011, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort after all A words and two B words.
    for (int i = 0; i < BEATS + 2; i++) send_word("abort", 32'hFFFF_FFFF, 1'b1);
    bus.in_WVALID = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_op_a", bus.out_OP_A, 128'h0);
    check("abort_op_b", bus.out_OP_B, 128'h0);
    check("abort_ci",   bus.out_CI,   1'b0);
    run_op("post_abort", 128'h5, 128'h7, 1'b0, 128'hC, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while a result is being offered.
    send_ops("rst_drain", 128'h5, 128'h7, 1'b0, 1'b0);
    wait_rvalid("rst_drain");
    check("rst_drain_rvalid_pre", bus.out_RVALID, 1'b1);
    check("rst_drain_rdata_pre",  bus.out_RDATA,  32'hC);
    rst = 1'b1;
    @(negedge clk);
    check("rst_drain_rvalid", bus.out_RVALID,  1'b0);
    check("rst_drain_result", bus.out_RDATA,   32'h0);
    check("rst_drain_co",     bus.out_CO_FLAG, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_drain_rvalid_after", bus.out_RVALID, 1'b0);

    run_op("gapped", 128'h00000001_FFFFFFFF_00000000_FFFFFFFF,
           128'h00000001_00000001_00000000_00000001, 1'b0,
           128'h00000003_00000000_00000001_00000000, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef RCA128_OVF_EN
    run_op("ovf_pos", {1'b0, {127{1'b1}}}, 128'h1, 1'b0,
           {1'b1, 127'h0}, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("ovf_neg", {1'b1, 127'h0}, {1'b1, 127'h0}, 1'b0,
           128'h0, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rca128_mc_ctrl.md
Name: rca128_mc_ctrl

Overview:
- Sequential front/back-end for the combinational 128-bit ripple-carry adder (VRCA_128).
- Assembles both 128-bit operands and carry-in from a 32-bit word stream, and holds them stable on the adder inputs for a fixed multicycle settle window.
- Captures sum and carry-out, then streams the result back as 32-bit words.
- The adder is instantiated beside this block, not inside it; the ripple path is constrained as a multicycle path of SETTLE_CYC cycles.

Parameters:
- WORD_W, 32, stream word width.
- OP_W, 128, operand/sum width; must be an integer multiple of WORD_W.
- SETTLE_CYC, 4, cycles operands are held before the sum is captured; legal range 1..15.

Ports:
- in_CLK  input  1  clock; all state changes on rising edge.
- in_RST  input  1  synchronous, active-high reset.
- in_WDATA  input  WORD_W  operand word, least-significant word first; A words then B words.
- in_WVALID  input  1  in_WDATA valid.
- in_CIN  input  1  carry-in, sampled with the first A word.
- out_WREADY  output  1  block accepts a word this cycle.
- out_OP_A  output  OP_W  registered operand A to the adder.
- out_OP_B  output  OP_W  registered operand B to the adder.
- out_CI  output  1  registered carry-in to the adder.
- in_SUM  input  OP_W  adder sum.
- in_CO  input  1  adder carry-out.
- out_RDATA  output  WORD_W  result word, least-significant word first.
- out_RVALID  output  1  out_RDATA valid.
- in_RREADY  input  1  downstream accepts the result word.
- out_RLAST  output  1  marks the final result word.
- out_CO_FLAG  output  1  captured carry-out; held valid while out_RVALID=1.

Behaviour:
- BEATS = OP_W/WORD_W (4 at the default).
- A word transfer occurs when in_WVALID & out_WREADY; a result transfer occurs when out_RVALID & in_RREADY.

FSM states: LOAD_A, LOAD_B, SETTLE, DRAIN. Reset state is LOAD_A.

- LOAD_A:
  - out_WREADY=1.
  - Each transfer writes word slot beat_cnt of A; beat_cnt increments.
  - in_CIN is latched on the beat_cnt==0 transfer.
  - After BEATS transfers: go to LOAD_B, beat_cnt=0.
- LOAD_B:
  - Same as LOAD_A, writing B.
  - After the last transfer: go to SETTLE, settle_cnt=0.
- SETTLE:
  - out_WREADY=0.
  - out_OP_A, out_OP_B and out_CI are held constant.
  - settle_cnt increments each cycle.
  - In the cycle where settle_cnt==SETTLE_CYC-1: register in_SUM into the result register and in_CO into out_CO_FLAG, then go to DRAIN with beat_cnt=0.
- DRAIN:
  - out_RVALID=1.
  - out_RDATA = result word beat_cnt.
  - out_RLAST=1 when beat_cnt==BEATS-1.
  - On each transfer beat_cnt increments; after the last transfer go to LOAD_A.
  - out_RDATA, out_RLAST and out_CO_FLAG stay stable while in_RREADY=0 (no drop, no advance).

Latency:
- Last B word accepted in cycle t; out_RVALID first high in cycle t+SETTLE_CYC+1.
- Minimum full operation is 2·BEATS + SETTLE_CYC + BEATS cycles.

Other rules:
- Operand registers change only on a write transfer; they are never written in SETTLE or DRAIN.
- in_WVALID outside the LOAD states is ignored (no transfer, no state change).
- The sum is modulo 2^OP_W; the carry is reported only via out_CO_FLAG.

Reset values (in_RST=1 takes priority in every state, including mid-load, mid-settle and mid-drain; partial data is discarded):
- out_OP_A=0, out_OP_B=0, out_CI=0.
- Result register=0, out_CO_FLAG=0.
- out_RVALID=0, out_RLAST=0.
- out_WREADY=0 during the reset cycle, 1 from the first cycle after reset is released.
- beat_cnt=0, settle_cnt=0.

Optional Feature:
- Macro: RCA128_OVF_EN.
- Defined:
  - Adds output port out_OVF (1 bit).
  - Captured together with out_CO_FLAG as (A[OP_W-1]==B[OP_W-1]) & (in_SUM[OP_W-1]!=A[OP_W-1]), using the registered operands.
  - Held while out_RVALID=1; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package rca_pkg holds:
  - FSM state enum (ST_LOAD_A, ST_LOAD_B, ST_SETTLE, ST_DRAIN).
  - Default constants WORD_W=32, OP_W=128.
  - Function beats(OP_W, WORD_W).
- One sub-module, rca_word_pack: a parameterised OP_W register with word-indexed write enable. It is instantiated twice, for A and for B.

Test Plan:
- Max carry: A=all-ones, B=0x1, CIN=0, SETTLE_CYC=4 -> RDATA words 0,0,0,0; CO_FLAG=1; RVALID rises exactly 5 cycles after the last B beat.
- Word ordering: A=0x00000004_00000003_00000002_00000001, B=0x00000040_00000030_00000020_00000010, CIN=1 -> RDATA 0x12, 0x22, 0x33, 0x44 in that order; RLAST only on 0x44; CO_FLAG=0.
- Backpressure: hold RREADY=0 for 7 cycles mid-drain after word 1 -> word 2 is held stable, no words are lost or duplicated, and out_WREADY stays 0 until the final transfer completes.
- Reset mid-operation: assert RST after 2 B words -> next operation with A=5, B=7, CIN=0 yields 0xC with no residue from the aborted data; reset while RVALID=1 drops RVALID next cycle.
- Gapped input: WVALID toggles every other cycle with WVALID asserted during SETTLE -> only 8 words are consumed; the extra words are not accepted; the sum is correct.
- RCA128_OVF_EN: A=0x7FFF…F, B=1 -> OVF=1, CO_FLAG=0; A=0x8000…0, B=0x8000…0 -> OVF=1, CO_FLAG=1, sum 0.
